// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a binary grant ID.
// Defining ARB_TIMEOUT_EN adds a watchdog that revokes a grant after MAX_HOLD cycles.
module rr_priority_arbiter #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [IDW-1:0] win;
  logic           found;
  logic           owner_rel;
  logic           expire;
  logic [N-1:0]   gnt_nxt;
  logic [IDW-1:0] id_nxt;
  logic           valid_nxt;

  if (N < 2 || N > 8 || (2 ** IDW) < N || MAX_HOLD < 2) begin : g_bad_param
    $error("rr_priority_arbiter: bad parameters");
  end

  // Walk from lowest to highest priority so the last hit (at ptr) wins.
  always_comb begin : search
    int t;
    t     = 0;
    win   = '0;
    found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      t = int'(ptr) - j;
      if (t < 0) t = t + N;
      if (req[t]) begin
        win   = IDW'(t);
        found = 1'b1;
      end
    end
  end

  assign owner_rel = done | ~req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold;

  assign expire = (state == GRANT) && (hold == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= '0;
      timeout <= 1'b0;
    end else begin
      hold    <= (state == GRANT) ? hold + 1'b1 : '0;
      timeout <= expire & ~owner_rel;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    valid_nxt = gnt_valid;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt      = '0;
          gnt_nxt[win] = 1'b1;
          id_nxt       = win;
          valid_nxt    = 1'b1;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (owner_rel | expire) begin
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
          state_nxt = IDLE;
          ptr_nxt   = (gnt_id == '0) ? IDW'(N - 1)
                                     : gnt_id - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IDW'(N - 1);
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= valid_nxt;
    end
  end

endmodule
